// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        LONG_OP  = 2'd2
    } state_t;

    // Per-stage enable/flush bundle driven to the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_DEFAULT = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b0,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0
    };

    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
        id_ex_en: 1'b0, id_ex_flush: 1'b1,
        ex_mem_en: 1'b0, ex_mem_flush: 1'b1
    };

    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0,
        ex_mem_en: 1'b0, ex_mem_flush: 1'b0
    };

    // Front of the pipe holds while EX is busy; a bubble drains into MEM.
    localparam pipe_ctrl_t CTRL_LONG = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b1
    };

    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
        id_ex_en: 1'b1, id_ex_flush: 1'b1,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0
    };

    localparam pipe_ctrl_t CTRL_LD_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b1, id_ex_flush: 1'b1,
        ex_mem_en: 1'b1, ex_mem_flush: 1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID source registers and the EX load destination.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             MemREAD_ex,
    output logic             hz_c
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = use_rs1_id && (rs1_id == rd_ex);
    assign rs2_match = use_rs2_id && (rs2_id == rd_ex);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign hz_c = MemREAD_ex && (rd_ex != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencer: load-use stall, branch redirect, long-op hold, memory freeze.
// Optional PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LONG_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             MemREAD_ex,
    input  logic             branch_taken_ex,
    input  logic             long_op_ex,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    localparam int unsigned CNT_W = $clog2(LONG_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LONG_LAT - 2);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hz_c;
    pipe_ctrl_t       ctrl_c;

    load_use_detect u_load_use_detect (
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .use_rs1_id (use_rs1_id),
        .use_rs2_id (use_rs2_id),
        .rd_ex      (rd_ex),
        .MemREAD_ex (MemREAD_ex),
        .hz_c       (hz_c)
    );

    // State and long-op counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mealy next-state and control decode.
    always_comb begin
        ctrl_c  = CTRL_DEFAULT;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!rst_n) begin
            ctrl_c  = CTRL_RESET;
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN, LD_STALL: begin
                    if (dmem_busy) begin
                        ctrl_c = CTRL_FREEZE;
                    end else if (long_op_ex) begin
                        ctrl_c  = CTRL_LONG;
                        cnt_d   = CNT_LOAD;
                        state_d = LONG_OP;
                    end else if (branch_taken_ex) begin
                        ctrl_c  = CTRL_BRANCH;
                        state_d = RUN;
                    end else if (hz_c && (state_q == RUN)) begin
                        // The re-issued instruction picks up the load result via MEM forwarding.
                        ctrl_c  = CTRL_LD_STALL;
                        state_d = LD_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                LONG_OP: begin
                    if (dmem_busy) begin
                        ctrl_c = CTRL_FREEZE;
                    end else if (cnt_q != '0) begin
                        ctrl_c = CTRL_LONG;
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pc_en        = ctrl_c.pc_en;
    assign if_id_en     = ctrl_c.if_id_en;
    assign if_id_flush  = ctrl_c.if_id_flush;
    assign id_ex_en     = ctrl_c.id_ex_en;
    assign id_ex_flush  = ctrl_c.id_ex_flush;
    assign ex_mem_en    = ctrl_c.ex_mem_en;
    assign ex_mem_flush = ctrl_c.ex_mem_flush;

`ifdef PIPE_PERF_CNT_EN
    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!ctrl_c.pc_en) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ctrl_c.if_id_flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios then randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int unsigned LONG_LAT = 4;

    // Expected control vectors: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush}
    localparam logic [6:0] E_RESET  = 7'b0010101;
    localparam logic [6:0] E_DEF    = 7'b1101010;
    localparam logic [6:0] E_FREEZE = 7'b0000000;
    localparam logic [6:0] E_LONG   = 7'b0000011;
    localparam logic [6:0] E_BR     = 7'b1111110;
    localparam logic [6:0] E_LD     = 7'b0001110;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       use_rs1_id, use_rs2_id, MemREAD_ex, branch_taken_ex, long_op_ex, dmem_busy;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    logic [31:0] m_stall, m_flush;
`endif

    int checks;
    int failures;

    // Model: 0 = running, 1 = just stalled for a load, 2 = long op occupying EX.
    int m_mode;
    int m_rem;

    pipe_hazard_ctrl #(.LONG_LAT(LONG_LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .use_rs1_id      (use_rs1_id),
        .use_rs2_id      (use_rs2_id),
        .rd_ex           (rd_ex),
        .MemREAD_ex      (MemREAD_ex),
        .branch_taken_ex (branch_taken_ex),
        .long_op_ex      (long_op_ex),
        .dmem_busy       (dmem_busy),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .ex_mem_flush    (ex_mem_flush)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
`endif

    // Reference behaviour derived from the hazard rules, in terms of remaining EX cycles.
    task automatic model_eval(output logic [6:0] e, output int nmode, output int nrem);
        logic hz;
        hz = MemREAD_ex && (rd_ex != 5'd0) &&
             ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
        nmode = m_mode;
        nrem  = m_rem;
        if (!rst_n) begin
            e = E_RESET; nmode = 0; nrem = 0;
        end else if (m_mode == 2) begin
            if (dmem_busy)      e = E_FREEZE;
            else if (m_rem > 1) begin e = E_LONG; nrem = m_rem - 1; end
            else                begin e = E_DEF; nmode = 0; end
        end else begin
            if (dmem_busy)                  e = E_FREEZE;
            else if (long_op_ex)            begin e = E_LONG; nmode = 2; nrem = LONG_LAT - 1; end
            else if (branch_taken_ex)       begin e = E_BR; nmode = 0; end
            else if (hz && m_mode == 0)     begin e = E_LD; nmode = 1; end
            else                            begin e = E_DEF; nmode = 0; end
        end
    endtask

    // One clock: check combinational outputs mid-low-phase, then advance the model on the edge.
    task automatic cyc(input string tag);
        logic [6:0] e;
        int nm, nr;
        #1;
        model_eval(e, nm, nr);
        check7(tag, {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush}, e);
`ifdef PIPE_PERF_CNT_EN
        check32({tag, "_stall_cnt"}, stall_cycles, m_stall);
        check32({tag, "_flush_cnt"}, flush_events, m_flush);
`endif
        @(posedge clk);
`ifdef PIPE_PERF_CNT_EN
        if (!rst_n) begin
            m_stall = '0; m_flush = '0;
        end else begin
            if (!e[6]) m_stall = m_stall + 32'd1;
            if (e[4])  m_flush = m_flush + 32'd1;
        end
`endif
        m_mode = nm;
        m_rem  = nr;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; MemREAD_ex = 1'b0;
        branch_taken_ex = 1'b0; long_op_ex = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        MemREAD_ex = 1'b1; rd_ex = rd; rs1_id = rd; use_rs1_id = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_mode = 0; m_rem = 0;
`ifdef PIPE_PERF_CNT_EN
        m_stall = '0; m_flush = '0;
`endif
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);

        repeat (3) cyc("reset");
        rst_n = 1'b1;
        cyc("idle_after_reset");

        // Load-use: one stall, then masked even if the same inputs persist.
        set_load_use(5'd5);
        cyc("lu_stall");
        cyc("lu_masked");
        idle_inputs();
        cyc("lu_after");

        set_load_use(5'd0);
        cyc("lu_rd_zero");
        idle_inputs();
        MemREAD_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; use_rs2_id = 1'b1;
        cyc("lu_rs2_stall");
        idle_inputs();
        cyc("lu_rs2_after");

        // Branch beats hazard; the following hazard still stalls, proving RUN was kept.
        set_load_use(5'd9);
        branch_taken_ex = 1'b1;
        cyc("br_hz");
        branch_taken_ex = 1'b0;
        cyc("br_then_hz");
        idle_inputs();
        cyc("br_idle");

        // Memory freeze holds LD_STALL; the held stall is then released with hazard masked.
        set_load_use(5'd3);
        cyc("ld_enter");
        dmem_busy = 1'b1;
        cyc("ld_busy");
        dmem_busy = 1'b0;
        cyc("ld_release");
        idle_inputs();

        // Long op: LONG_LAT cycles of EX occupancy.
        long_op_ex = 1'b1;
        for (int i = 0; i < int'(LONG_LAT); i++) cyc("long_plain");
        long_op_ex = 1'b0;
        cyc("long_plain_after");

        // Long op with two memory-busy cycles: occupancy grows to LONG_LAT + 2.
        long_op_ex = 1'b1;
        cyc("long_busy_entry");
        dmem_busy = 1'b1;
        cyc("long_busy_freeze");
        cyc("long_busy_freeze");
        dmem_busy = 1'b0;
        for (int i = 0; i < int'(LONG_LAT) - 1; i++) cyc("long_busy_tail");
        long_op_ex = 1'b0;
        cyc("long_busy_after");

        // Reset mid long op aborts; a fresh long op takes the full latency.
        long_op_ex = 1'b1;
        cyc("long_abort_entry");
        cyc("long_abort_mid");
        rst_n = 1'b0;
        cyc("long_abort_reset");
        rst_n = 1'b1;
        for (int i = 0; i < int'(LONG_LAT); i++) cyc("long_fresh");
        long_op_ex = 1'b0;
        cyc("long_fresh_after");

        // Randomized traffic with collision-prone register fields.
        for (int n = 0; n < 600; n++) begin
            rst_n           = ($urandom_range(0, 99) >= 3);
            dmem_busy       = ($urandom_range(0, 99) < 20);
            long_op_ex      = ($urandom_range(0, 99) < 10);
            branch_taken_ex = ($urandom_range(0, 99) < 15);
            MemREAD_ex      = ($urandom_range(0, 99) < 50);
            use_rs1_id      = ($urandom_range(0, 99) < 70);
            use_rs2_id      = ($urandom_range(0, 99) < 50);
            rd_ex           = 5'($urandom_range(0, 3));
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
